// File: rtl/addr_gen_unit_pkg.sv
// Shared definitions for the address generation unit: FSM encoding and the
// default address width used by PC/IR datapaths.
package addr_gen_unit_pkg;

    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FIN   = 2'd2
    } agu_state_t;

endpackage

// File: rtl/addr_src_mux.sv
// NUM_SRC:1 combinational address mux; out-of-range selects yield zero and
// raise range_err.
module addr_src_mux #(
    parameter int ADDR_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC*ADDR_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          src_sel,
    output logic [ADDR_W-1:0]         addr,
    output logic                      range_err
);

    always_comb begin
        addr      = '0;
        range_err = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                addr      = src_bus[k*ADDR_W +: ADDR_W];
                range_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/addr_gen_unit.sv
// Registered MAR with source select and an auto-incrementing req/ack burst engine.
//   state | meaning
//   IDLE  | waiting for load/start
//   BURST | mem_req asserted, advancing MAR on each ack
//   FIN   | one-cycle done pulse
module addr_gen_unit
    import addr_gen_unit_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int BURST_W = 4,
    parameter int STRIDE  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      load,
    input  logic                      start,
    input  logic [BURST_W-1:0]        burst_len,
    input  logic                      abort,
    input  logic                      mem_ack,
    output logic [ADDR_W-1:0]         mar_out,
    output logic                      mem_req,
    output logic                      busy,
    output logic                      done,
    output logic                      sel_err,
    output logic                      wrapped
);

    localparam logic [ADDR_W:0] STRIDE_EXT = (ADDR_W+1)'(STRIDE);

    agu_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  mar, mar_nxt;
    logic [BURST_W-1:0] cnt, cnt_nxt;
    logic               err, err_nxt;
    logic               wrap, wrap_nxt;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_bad;
    logic [ADDR_W:0]    inc_sum;

    addr_src_mux #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_bus   (src_bus),
        .src_sel   (src_sel),
        .addr      (sel_addr),
        .range_err (sel_bad)
    );

    // Extra MSB captures the carry that signals wrap past all-ones.
    assign inc_sum = {1'b0, mar} + STRIDE_EXT;

    always_comb begin
        state_nxt = state;
        mar_nxt   = mar;
        cnt_nxt   = cnt;
        err_nxt   = err;
        wrap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if ((start || load) && sel_bad)
                    err_nxt = 1'b1;
                if (start) begin
                    if (burst_len != '0) begin
                        mar_nxt   = sel_addr;
                        cnt_nxt   = burst_len;
                        state_nxt = BURST;
                    end
                end else if (load) begin
                    mar_nxt = sel_addr;
                end
            end
            BURST: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (mem_ack) begin
                    if (cnt == BURST_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = FIN;
                    end else begin
                        mar_nxt  = inc_sum[ADDR_W-1:0];
                        wrap_nxt = inc_sum[ADDR_W];
                        cnt_nxt  = cnt - BURST_W'(1);
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mar   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            mar   <= mar_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
            wrap  <= wrap_nxt;
        end
    end

    assign mar_out = mar;
    assign mem_req = (state == BURST);
    assign busy    = (state == BURST);
    assign done    = (state == FIN);
    assign sel_err = err;
    assign wrapped = wrap;

endmodule

// File: tb/tb_addr_gen_unit.sv
// Directed and random stimulus for addr_gen_unit with three sources, so that
// select 3 is out of range; outputs are compared against a behavioural model.
module tb_addr_gen_unit;

    localparam int AW = 16;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] src [NS];
    logic [NS*AW-1:0] src_bus;
    logic [1:0]    src_sel = '0;
    logic          load = 1'b0, start = 1'b0, abort = 1'b0, mem_ack = 1'b0;
    logic [3:0]    burst_len = '0;
    logic [AW-1:0] mar_out;
    logic          mem_req, busy, done, sel_err, wrapped;

    int total = 0;
    int bad   = 0;

    // reference model: address, beats still to be acknowledged, flags
    int m_mar, m_left;
    bit m_fin, m_err, m_wrap;

    assign src_bus = {src[2], src[1], src[0]};

    always #5 clk = ~clk;

    addr_gen_unit #(
        .ADDR_W (AW), .NUM_SRC (NS), .SEL_W (2), .BURST_W (4), .STRIDE (1)
    ) dut (
        .clk (clk), .rst (rst), .src_bus (src_bus), .src_sel (src_sel),
        .load (load), .start (start), .burst_len (burst_len), .abort (abort),
        .mem_ack (mem_ack), .mar_out (mar_out), .mem_req (mem_req), .busy (busy),
        .done (done), .sel_err (sel_err), .wrapped (wrapped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sel_value();
        if (int'(src_sel) >= NS) return 0;
        return int'(src[src_sel]);
    endfunction

    task automatic model_step();
        m_wrap = 1'b0;
        if (rst) begin
            m_mar = 0; m_left = 0; m_fin = 1'b0; m_err = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0;
            end else if (mem_ack) begin
                if (m_left == 1) begin
                    m_left = 0;
                    m_fin  = 1'b1;
                end else begin
                    m_wrap = (m_mar + 1) > 65535;
                    m_mar  = (m_mar + 1) % 65536;
                    m_left = m_left - 1;
                end
            end
        end else begin
            if ((start || load) && int'(src_sel) >= NS) m_err = 1'b1;
            if (start) begin
                if (burst_len != 0) begin
                    m_mar  = sel_value();
                    m_left = int'(burst_len);
                end
            end else if (load) begin
                m_mar = sel_value();
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("mar_out", 32'(mar_out), 32'(m_mar));
        chk("mem_req", 32'(mem_req), 32'(m_left > 0));
        chk("busy",    32'(busy),    32'(m_left > 0));
        chk("done",    32'(done),    32'(m_fin));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        chk("wrapped", 32'(wrapped), 32'(m_wrap));
    endtask

    initial begin
        src[0] = 16'h1000; src[1] = 16'h2000; src[2] = 16'h3000;
        m_mar = 0; m_left = 0; m_fin = 1'b0; m_err = 1'b0; m_wrap = 1'b0;

        // reset, then load source 2
        rst = 1'b1; tick(); tick();
        chk("reset_mar", 32'(mar_out), 32'h0);
        rst = 1'b0; tick();
        src_sel = 2'd2; load = 1'b1; tick(); load = 1'b0;
        chk("load_mar", 32'(mar_out), 32'h3000);
        chk("load_noreq", 32'(mem_req), 32'h0);

        // three-beat burst, ack every cycle
        src_sel = 2'd0; burst_len = 4'd3; start = 1'b1; tick(); start = 1'b0;
        chk("b1_first", 32'(mar_out), 32'h1000);
        mem_ack = 1'b1; tick();
        chk("b1_second", 32'(mar_out), 32'h1001);
        tick();
        chk("b1_third", 32'(mar_out), 32'h1002);
        tick();
        chk("b1_done", 32'(done), 32'h1);
        chk("b1_hold", 32'(mar_out), 32'h1002);
        mem_ack = 1'b0; tick();
        chk("b1_done_clear", 32'(done), 32'h0);

        // stalled ack and wrap from FFFF
        src[0] = 16'hFFFF; burst_len = 4'd2; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        chk("stall_hold", 32'(mar_out), 32'hFFFF);
        mem_ack = 1'b1; tick();
        chk("wrap_mar", 32'(mar_out), 32'h0);
        chk("wrap_flag", 32'(wrapped), 32'h1);
        tick();
        chk("wrap_done", 32'(done), 32'h1);
        mem_ack = 1'b0; tick();

        // abort together with the second ack
        src[0] = 16'h1000; burst_len = 4'd5; start = 1'b1; tick(); start = 1'b0;
        mem_ack = 1'b1; tick();
        abort = 1'b1; tick(); abort = 1'b0; mem_ack = 1'b0;
        chk("abort_mar", 32'(mar_out), 32'h1001);
        chk("abort_idle", 32'(busy), 32'h0);
        tick();
        chk("abort_nodone", 32'(done), 32'h0);
        src_sel = 2'd1; load = 1'b1; tick(); load = 1'b0;
        chk("abort_reload", 32'(mar_out), 32'h2000);

        // out-of-range select is sticky until reset
        src_sel = 2'd3; load = 1'b1; tick();
        chk("oor_mar", 32'(mar_out), 32'h0);
        chk("oor_err", 32'(sel_err), 32'h1);
        src_sel = 2'd0; tick(); load = 1'b0;
        chk("oor_sticky", 32'(sel_err), 32'h1);

        // reset mid-burst
        burst_len = 4'd4; start = 1'b1; tick(); start = 1'b0;
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(sel_err), 32'h0);

        // zero-length start, start+load, start while busy
        burst_len = 4'd0; start = 1'b1; tick(); start = 1'b0;
        chk("len0_noreq", 32'(mem_req), 32'h0);
        src_sel = 2'd2; burst_len = 4'd2; start = 1'b1; load = 1'b1; tick(); load = 1'b0;
        chk("startload_busy", 32'(busy), 32'h1);
        src_sel = 2'd1; burst_len = 4'd7; tick(); start = 1'b0;
        chk("busy_start_ign", 32'(mar_out), 32'h3000);
        mem_ack = 1'b1; tick(); tick();
        start = 1'b1; tick(); start = 1'b0; mem_ack = 1'b0;
        chk("fin_start_ign", 32'(busy), 32'h0);
        tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            start     = ($urandom_range(0, 4) == 0);
            load      = ($urandom_range(0, 4) == 0);
            abort     = ($urandom_range(0, 11) == 0);
            mem_ack   = ($urandom_range(0, 2) != 0);
            src_sel   = 2'($urandom_range(0, 3));
            burst_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < NS; k++)
                    src[k] = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                         : 16'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addr_gen_unit.md
Name: addr_gen_unit

Overview:
Parametrised successor of the MAR input mux. Selects one of NUM_SRC address sources (PC, data bus, IR low field, SP, ...) into an internal registered MAR. Optionally runs an auto-incrementing burst of memory requests from that base address with a req/ack handshake. Sits between the address sources and the memory interface; replaces the mux-plus-MAR pair.

Parameters:
ADDR_W, 16, address width in bits
NUM_SRC, 4, number of address sources (>=2)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC
BURST_W, 4, burst length counter width
STRIDE, 1, MAR increment per accepted beat

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
src_bus  in  NUM_SRC*ADDR_W  packed sources; source k = bits [k*ADDR_W +: ADDR_W]
src_sel  in  SEL_W  source select
load  in  1  load selected source into MAR, no memory request
start  in  1  begin burst from selected source
burst_len  in  BURST_W  beats in burst (0 = invalid)
abort  in  1  terminate active burst
mem_ack  in  1  memory accepted current beat
mar_out  out  ADDR_W  current MAR value (memory address)
mem_req  out  1  request valid for mar_out
busy  out  1  burst active
done  out  1  one-cycle pulse after last beat accepted
sel_err  out  1  sticky: out-of-range select used
wrapped  out  1  one-cycle pulse when increment wrapped past all-ones

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst, the codebase's clock and reset port names.
- Reset (dominates all inputs, including mid-burst): mar_out=0, mem_req=0, busy=0, done=0, sel_err=0, wrapped=0, beat counter=0, state=IDLE.
- Source selection is combinational. src_sel >= NUM_SRC selects all-zero and sets sel_err on the edge where it is consumed (load or start). sel_err clears only on reset.
- FSM states IDLE, BURST, FIN.
- IDLE:
  - start=1 with burst_len!=0: MAR<=selected source, cnt<=burst_len, go to BURST. Start wins over a simultaneous load.
  - start=1 with burst_len=0: ignored, except the sel_err update.
  - load=1 (no start): MAR<=selected source; stay IDLE.
  - mem_ack and abort are ignored.
- BURST:
  - mem_req=1, busy=1; mar_out stable until ack.
  - On mem_ack with cnt>1: MAR<=MAR+STRIDE modulo 2**ADDR_W, cnt<=cnt-1. If the addition carries out, wrapped=1 for one cycle.
  - On mem_ack with cnt==1: MAR unchanged (last beat address retained), go to FIN.
  - abort=1: go to IDLE next cycle with no done. Abort wins over a simultaneous mem_ack, and that beat is not counted.
  - load and start are ignored while busy.
- FIN: done=1, mem_req=0, busy=0 for exactly one cycle, then IDLE. A start during FIN is ignored.
- Latency: start to first mem_req = 1 cycle. Ack of last beat to done = 1 cycle.
- mem_req deasserts in the cycle after the final ack.
- A back-to-back ack every cycle yields one beat per cycle.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, BURST=2'd1, FIN=2'd2) and a default ADDR_W constant shared with PC/IR.
- One natural sub-module: addr_src_mux, the parametrised combinational NUM_SRC:1 mux with range-error output, reused elsewhere.
- FSM, counter and MAR stay in the top module.

Test Plan:
- Reset then load: src_bus={16'h4000,16'h3000,16'h2000,16'h1000}, src_sel=2, load=1 -> next cycle mar_out=16'h3000, mem_req=0, busy=0.
- Burst with one-cycle acks: src_sel=0, burst_len=3, start, ack every cycle -> mar_out 1000,1001,1002 on successive req cycles. done pulses one cycle after the third ack; mar_out stays 1002.
- Stalled ack plus wrap: source=16'hFFFF, burst_len=2, ack held low 3 cycles then pulsed -> mar_out holds FFFF during stall, then 0000 with wrapped=1 for one cycle, then done.
- Abort mid-burst: burst_len=5, abort asserted together with the 2nd ack -> IDLE next cycle, done never asserts, mar_out=base+1. A subsequent load works.
- Out-of-range select: NUM_SRC=3, src_sel=3, load -> mar_out=0, sel_err=1, and sel_err stays set after later valid loads until rst.
- Reset mid-burst and ignored inputs: rst during BURST -> all outputs 0 next cycle. start with burst_len=0 -> no req. start+load together -> burst starts. start during busy -> ignored.
